// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the alu_muldiv execute unit: MIPS funct codes,
// mul/div FSM state encodings and small decode helpers.
package alu_muldiv_pkg;

  localparam int FUNCT_W = 6;

  // Single-cycle ALU functions
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;

  // HI/LO moves
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  // Iterative multiply / divide
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // Mul/div sequencer states
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ITER  = 2'b01;
  localparam logic [1:0] ST_FIX   = 2'b10;

  // Flavour of a mul/div request handed to the core
  typedef struct packed {
    logic signed_op;
    logic is_div;
  } md_kind_t;

  // True for the four funct codes that run through the iterative core
  function automatic logic is_muldiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  // Split a mul/div funct code into signedness and operation
  function automatic md_kind_t decode_md(input logic [5:0] fn);
    md_kind_t k;
    k.signed_op = (fn == FN_MULT) || (fn == FN_DIV);
    k.is_div    = (fn == FN_DIV)  || (fn == FN_DIVU);
    return k;
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the EX-stage control and alu_muldiv.
// The pipeline side is the master, the execute unit is the slave.
interface alu_muldiv_if
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [FUNCT_W-1:0] alu_control;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;

  modport master (
    output in_valid, a, b, alu_control,
    input  in_ready, out_valid, result, zero, hi, lo, busy
  );

  modport slave (
    input  in_valid, a, b, alu_control,
    output in_ready, out_valid, result, zero, hi, lo, busy
  );

endinterface

// File: rtl/alu_muldiv_core.sv
// Iterative multiply/divide engine. Works on operand magnitudes for WIDTH
// cycles (shift-add multiply or restoring divide), then applies the sign
// correction during one FIX cycle while done is high.
module muldiv_core
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               div_mode;
  logic               a_neg;
  logic               b_neg;
  logic               div_zero;
  logic [WIDTH-1:0]   a_raw;
  // multiplicand for MULT*, divisor for DIV*
  logic [WIDTH-1:0]   opnd;
  // MULT*: running product {acc_hi, acc_lo}; DIV*: remainder / quotient
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_fit;
  logic [WIDTH-1:0]   nxt_hi;
  logic [WIDTH-1:0]   nxt_lo;
  logic [2*WIDTH-1:0] prod;

  // Two's-complement magnitude when the operand is treated as signed
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic en);
    return (en && x[WIDTH-1]) ? -x : x;
  endfunction

  assign done = (state == ST_FIX);

  // One iteration step: add-and-shift-right for multiply, shift-and-subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_fit   = (div_shift >= {1'b0, opnd});
    nxt_hi    = acc_hi;
    nxt_lo    = acc_lo;
    if (div_mode) begin
      if (div_fit) begin
        nxt_hi = WIDTH'(div_shift - {1'b0, opnd});
      end else begin
        nxt_hi = div_shift[WIDTH-1:0];
      end
      nxt_lo = {acc_lo[WIDTH-2:0], div_fit};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Final sign correction; divide-by-zero bypasses it and reports all-ones / dividend
  always_comb begin
    prod   = {acc_hi, acc_lo};
    hi_out = acc_hi;
    lo_out = acc_lo;
    if (div_mode) begin
      if (div_zero) begin
        lo_out = {WIDTH{1'b1}};
        hi_out = a_raw;
      end else begin
        lo_out = (a_neg ^ b_neg) ? -acc_lo : acc_lo;
        hi_out = a_neg ? -acc_hi : acc_hi;
      end
    end else begin
      {hi_out, lo_out} = (a_neg ^ b_neg) ? -prod : prod;
    end
  end

  // Sequencer IDLE -> ITER (WIDTH steps) -> FIX -> IDLE and the working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= {CW{1'b0}};
      div_mode <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= {WIDTH{1'b0}};
      opnd     <= {WIDTH{1'b0}};
      acc_hi   <= {WIDTH{1'b0}};
      acc_lo   <= {WIDTH{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ITER;
            cnt      <= {CW{1'b0}};
            div_mode <= is_div;
            a_neg    <= signed_op & a[WIDTH-1];
            b_neg    <= signed_op & b[WIDTH-1];
            div_zero <= (b == {WIDTH{1'b0}});
            a_raw    <= a;
            acc_hi   <= {WIDTH{1'b0}};
            if (is_div) begin
              acc_lo <= magnitude(a, signed_op);
              opnd   <= magnitude(b, signed_op);
            end else begin
              acc_lo <= magnitude(b, signed_op);
              opnd   <= magnitude(a, signed_op);
            end
          end
        end
        ST_ITER: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          if (cnt == CNT_LAST) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage integer execute unit: single-cycle ALU ops, HI/LO moves and an
// iterative multiply/divide core. One op in flight; all outputs registered.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_muldiv_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  logic             accept;
  logic             md_op;
  md_kind_t         kind;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] single_res;
  logic             core_done;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;

  assign accept = bus.in_valid & bus.in_ready;
  assign md_op  = is_muldiv(bus.alu_control);
  assign kind   = decode_md(bus.alu_control);
  assign sh     = bus.b[SHW-1:0];

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (accept & md_op),
    .signed_op (kind.signed_op),
    .is_div    (kind.is_div),
    .a         (bus.a),
    .b         (bus.b),
    .done      (core_done),
    .hi_out    (core_hi),
    .lo_out    (core_lo)
  );

  // Result of every latency-1 function; unknown codes produce zero
  always_comb begin
    single_res = {WIDTH{1'b0}};
    case (bus.alu_control)
      FN_ADD:  single_res = bus.a + bus.b;
      FN_SUB:  single_res = bus.a - bus.b;
      FN_AND:  single_res = bus.a & bus.b;
      FN_OR:   single_res = bus.a | bus.b;
      FN_XOR:  single_res = bus.a ^ bus.b;
      FN_NOR:  single_res = ~(bus.a | bus.b);
      FN_SLT:  single_res = ($signed(bus.a) < $signed(bus.b)) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                                               : {WIDTH{1'b0}};
      FN_SLL:  single_res = bus.a << sh;
      FN_SRL:  single_res = bus.a >> sh;
      FN_SRA:  single_res = $signed(bus.a) >>> sh;
      FN_MFHI: single_res = bus.hi;
      FN_MFLO: single_res = bus.lo;
      FN_MTHI: single_res = bus.a;
      FN_MTLO: single_res = bus.a;
      default: single_res = {WIDTH{1'b0}};
    endcase
  end

  // Handshake, registered result/zero and the architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result    <= {WIDTH{1'b0}};
      bus.zero      <= 1'b1;
      bus.hi        <= {WIDTH{1'b0}};
      bus.lo        <= {WIDTH{1'b0}};
    end else begin
      bus.out_valid <= 1'b0;
      if (accept) begin
        if (md_op) begin
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b1;
        end else begin
          bus.out_valid <= 1'b1;
          bus.result    <= single_res;
          bus.zero      <= (single_res == {WIDTH{1'b0}});
          if (bus.alu_control == FN_MTHI) begin
            bus.hi <= bus.a;
          end
          if (bus.alu_control == FN_MTLO) begin
            bus.lo <= bus.a;
          end
        end
      end else if (core_done) begin
        bus.in_ready  <= 1'b1;
        bus.busy      <= 1'b0;
        bus.out_valid <= 1'b1;
        bus.result    <= core_lo;
        bus.zero      <= (core_lo == {WIDTH{1'b0}});
        bus.hi        <= core_hi;
        bus.lo        <= core_lo;
      end
    end
  end

endmodule
